// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      POWERUP, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE
   } lcd_state_e;

   localparam logic [7:0] FUNC_SET = 8'h38;
   localparam logic [7:0] DISP_ON  = 8'h0C;
   localparam logic [7:0] CLEAR    = 8'h01;
   localparam logic [7:0] ENTRY    = 8'h06;

   localparam int INIT_LEN = 6;
   localparam logic [7:0] INIT_ROM [INIT_LEN] =
      '{FUNC_SET, FUNC_SET, FUNC_SET, DISP_ON, CLEAR, ENTRY};

   // Clear (0x01) and home (0x02/0x03) need the long execution time.
   function automatic logic long_cmd(input logic rs, input logic [7:0] d);
      return !rs && (d[7:2] == 6'd0);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module lcd_timer #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          done
);

   logic [CW-1:0] cnt;

   // Load has priority; otherwise count down and stop at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          cnt <= '0;
      else if (load)       cnt <= load_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write-only controller: power-up wait, init sequence, then
// one byte per handshake with SETUP / E pulse / HOLD / execution wait.
// T_POWER is expected to be at least 2.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int T_POWER = 480000,
   parameter int T_E     = 6,
   parameter int T_EXEC  = 480,
   parameter int T_CLEAR = 19680
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       init_done,
   output logic       RS,
   output logic       RW,
   output logic       E,
   output logic       LCD_DB0,
   output logic       LCD_DB1,
   output logic       LCD_DB2,
   output logic       LCD_DB3,
   output logic       LCD_DB4,
   output logic       LCD_DB5,
   output logic       LCD_DB6,
   output logic       LCD_DB7
);

   localparam int CW = $clog2(max4(T_POWER, T_E, T_EXEC, T_CLEAR) + 1);
   // Power-up loads one less: the arming edge is itself the first counted cycle.
   localparam logic [CW-1:0] LD_POWER = CW'(T_POWER - 2);
   localparam logic [CW-1:0] LD_E     = CW'(T_E - 1);
   localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
   localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);

   lcd_state_e    state, state_d;
   logic          pwr_arm;
   logic [2:0]    idx;
   logic          rs_q;
   logic [7:0]    db_q;
   logic          wait_long;

   logic          tmr_load, tmr_done;
   logic [CW-1:0] tmr_val;
   logic          latch, lat_rs, lat_long;
   logic [7:0]    lat_data;
   logic          arm, idx_inc, set_done;

   lcd_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= POWERUP;
      else      state <= state_d;
   end

   // Next-state and control decode.
   always_comb begin
      state_d  = state;
      tmr_load = 1'b0;
      tmr_val  = '0;
      latch    = 1'b0;
      lat_rs   = 1'b0;
      lat_data = 8'h00;
      lat_long = 1'b0;
      arm      = 1'b0;
      idx_inc  = 1'b0;
      set_done = 1'b0;
      case (state)
         POWERUP: begin
            if (!pwr_arm) begin
               tmr_load = 1'b1;
               tmr_val  = LD_POWER;
               arm      = 1'b1;
            end else if (tmr_done) begin
               state_d = INIT_LOAD;
            end
         end
         INIT_LOAD: begin
            latch    = 1'b1;
            lat_data = INIT_ROM[idx];
            lat_long = (idx < 3'd3) || long_cmd(1'b0, INIT_ROM[idx]);
            state_d  = SETUP;
         end
         SETUP: begin
            tmr_load = 1'b1;
            tmr_val  = LD_E;
            state_d  = PULSE;
         end
         PULSE: if (tmr_done) state_d = HOLD;
         HOLD: begin
            tmr_load = 1'b1;
            tmr_val  = wait_long ? LD_CLEAR : LD_EXEC;
            state_d  = WAIT;
         end
         WAIT: begin
            if (tmr_done) begin
               if (init_done) begin
                  state_d = IDLE;
               end else if (idx == 3'(INIT_LEN - 1)) begin
                  set_done = 1'b1;
                  state_d  = IDLE;
               end else begin
                  idx_inc = 1'b1;
                  state_d = INIT_LOAD;
               end
            end
         end
         IDLE: begin
            if (in_valid) begin
               latch    = 1'b1;
               lat_rs   = in_rs;
               lat_data = in_data;
               lat_long = long_cmd(in_rs, in_data);
               state_d  = SETUP;
            end
         end
         default: state_d = POWERUP;
      endcase
   end

   // Datapath: bus registers hold the last written byte until the next latch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pwr_arm   <= 1'b0;
         idx       <= 3'd0;
         rs_q      <= 1'b0;
         db_q      <= 8'h00;
         wait_long <= 1'b0;
         init_done <= 1'b0;
      end else begin
         if (arm)      pwr_arm   <= 1'b1;
         if (idx_inc)  idx       <= idx + 3'd1;
         if (set_done) init_done <= 1'b1;
         if (latch) begin
            rs_q      <= lat_rs;
            db_q      <= lat_data;
            wait_long <= lat_long;
         end
      end
   end

   assign in_ready = (state == IDLE);
   assign E        = (state == PULSE);
   assign RW       = 1'b0;
   assign RS       = rs_q;
   assign {LCD_DB7, LCD_DB6, LCD_DB5, LCD_DB4,
           LCD_DB3, LCD_DB2, LCD_DB1, LCD_DB0} = db_q;

endmodule
